// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB payload definition for the CDB write-port arbiter and its producers.
package cdb_arbiter_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_TAG_W = 5;

  // One CDB broadcast: qualifier, result value and destination ROB tag.
  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      value;
    logic [ROB_TAG_W-1:0] rob_tag;
  } cdb_data_t;

endpackage

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single CDB write port between NUM_SRC result producers.
// Each source has a FIFO_DEPTH-entry FIFO; one head is popped per cycle by a
// round-robin arbiter and broadcast from a registered output.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   squash      branch mispredict flush; clears every FIFO, blocks push and grant
//   src_data    per-source result, qualified by .valid
//   src_stall   per-source backpressure (FIFO full), from registered counts only
//   cdb_out     registered CDB broadcast (valid, value, rob_tag)
//   cdb_src_id  source index that produced cdb_out (debug / perf)
//
// Build option: define CDB_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer). Default is round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       squash,
  input  cdb_data_t                  src_data [NUM_SRC],
  output logic [NUM_SRC-1:0]         src_stall,
  output cdb_data_t                  cdb_out,
  output logic [$clog2(NUM_SRC)-1:0] cdb_src_id
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0] count  [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr [NUM_SRC];
  cdb_data_t        mem    [NUM_SRC][FIFO_DEPTH];

  logic [NUM_SRC-1:0] push_c;
  logic [NUM_SRC-1:0] pop_c;
  logic [NUM_SRC-1:0] nonempty_c;
  logic               grant_c;
  logic [SRC_W-1:0]   winner_c;
  cdb_data_t          cdb_nxt_c;

  // Stall and push qualification; a slot freed by this cycle's pop is not reusable until next cycle.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_stall[i]  = (count[i] == CNT_W'(FIFO_DEPTH));
      nonempty_c[i] = (count[i] != '0);
      push_c[i]     = src_data[i].valid && !src_stall[i] && !squash;
    end
  end

`ifdef CDB_ARB_FIXED_PRIO_EN
  // Fixed priority: scan downwards so the lowest non-empty index is kept.
  always_comb begin
    grant_c  = 1'b0;
    winner_c = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (nonempty_c[k]) begin
        grant_c  = 1'b1;
        winner_c = SRC_W'(k);
      end
    end
  end
`else
  logic [SRC_W-1:0] rr_ptr;

  // Round-robin: scan offsets downwards so the smallest offset from rr_ptr is kept.
  always_comb begin
    logic [SRC_W-1:0] idx;
    grant_c  = 1'b0;
    winner_c = '0;
    idx      = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = SRC_W'((32'(rr_ptr) + 32'(k)) % NUM_SRC);
      if (nonempty_c[idx]) begin
        grant_c  = 1'b1;
        winner_c = idx;
      end
    end
  end

  // Pointer moves past the winner only on a real grant; squash leaves it alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant_c && !squash) begin
      rr_ptr <= (winner_c == SRC_W'(NUM_SRC - 1)) ? '0 : winner_c + SRC_W'(1);
    end
  end
`endif

  // Pop select and next broadcast word built from the winner's head.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      pop_c[i] = grant_c && !squash && (winner_c == SRC_W'(i));
    end
    cdb_nxt_c       = mem[winner_c][rd_ptr[winner_c]];
    cdb_nxt_c.valid = 1'b1;
  end

  // FIFO bookkeeping; squash discards everything buffered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else if (squash) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push_c[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop_c[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push_c[i] && !pop_c[i]) begin
          count[i] <= count[i] + CNT_W'(1);
        end else if (!push_c[i] && pop_c[i]) begin
          count[i] <= count[i] - CNT_W'(1);
        end
      end
    end
  end

  // FIFO storage; contents are don't-care until a pointer reaches them.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push_c[i]) mem[i][wr_ptr[i]] <= src_data[i];
    end
  end

  // Broadcast register; cleared to all-zero on every no-grant cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cdb_out    <= '0;
      cdb_src_id <= '0;
    end else if (grant_c && !squash) begin
      cdb_out    <= cdb_nxt_c;
      cdb_src_id <= winner_c;
    end else begin
      cdb_out <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (NUM_SRC=3, FIFO_DEPTH=2).
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned NS = 3;

  logic          clock;
  logic          reset_n;
  logic          squash;
  cdb_data_t     src_data [NS];
  logic [NS-1:0] src_stall;
  cdb_data_t     cdb_out;
  logic [1:0]    cdb_src_id;

  int tests_run;
  int tests_failed;

  // Per-source stimulus: item k = {value base+k, tag tbase+k}, presented while nxt < lim.
  logic [31:0] base  [NS];
  int          tbase [NS];
  int          lim   [NS];
  int          nxt   [NS];

  cdb_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .squash     (squash),
    .src_data   (src_data),
    .src_stall  (src_stall),
    .cdb_out    (cdb_out),
    .cdb_src_id (cdb_src_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cdb_data_t mk(input logic [31:0] v, input int t);
    cdb_data_t d;
    d.valid   = 1'b1;
    d.value   = v;
    d.rob_tag = 5'(t);
    return d;
  endfunction

  function automatic cdb_data_t item(input int s, input int k);
    return mk(base[s] + 32'(k), tbase[s] + k);
  endfunction

  task automatic check_cdb(input string tag, input cdb_data_t exp, input logic [1:0] exp_id);
    check({tag, ".cdb"}, 64'(cdb_out), 64'(exp));
    if (exp.valid) check({tag, ".id"}, 64'(cdb_src_id), 64'(exp_id));
  endtask

  // Present pending items with a valid/stall handshake, then advance one clock.
  task automatic tick();
    logic [NS-1:0] acc;
    for (int i = 0; i < NS; i++) begin
      src_data[i] = (nxt[i] < lim[i]) ? item(i, nxt[i]) : '0;
      acc[i] = src_data[i].valid && !src_stall[i] && !squash;
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < NS; i++) if (acc[i]) nxt[i]++;
  endtask

  task automatic do_reset();
    squash = 1'b0;
    for (int i = 0; i < NS; i++) begin
      src_data[i] = '0;
      lim[i]      = 0;
      nxt[i]      = 0;
      base[i]     = 32'h1000 * 32'(i + 1);
      tbase[i]    = 8 * i;
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    squash       = 1'b0;
    reset_n      = 1'b0;
    for (int i = 0; i < NS; i++) src_data[i] = '0;
    #12;
    check("rst.cdb", 64'(cdb_out), 64'h0);
    check("rst.id", 64'(cdb_src_id), 64'h0);
    check("rst.stall", 64'(src_stall), 64'h0);

    // Single result from source 1: broadcast two cycles later, then idle.
    do_reset();
    base[1] = 32'h0000_00AA; tbase[1] = 5; lim[1] = 1;
    tick();
    check_cdb("t1.e1", '0, 2'd0);
    tick();
    check_cdb("t1.e2", mk(32'h0000_00AA, 5), 2'd1);
    tick();
    check_cdb("t1.e3", '0, 2'd0);

`ifndef CDB_ARB_FIXED_PRIO_EN
    // All three sources backlogged: rotation 0,1,2 and in-order per source.
    do_reset();
    for (int i = 0; i < NS; i++) lim[i] = 100;
    tick();
    check_cdb("t2.e1", '0, 2'd0);
    check("t2.e1.stall", 64'(src_stall), 64'b000);
    for (int k = 2; k <= 8; k++) begin
      logic [2:0] es;
      int s;
      int n;
      tick();
      s = (k - 2) % 3;
      n = (k - 2) / 3;
      if (k == 2)                es = 3'b110;
      else if ((k - 3) % 3 == 0) es = 3'b101;
      else if ((k - 3) % 3 == 1) es = 3'b011;
      else                       es = 3'b110;
      check_cdb($sformatf("t2.e%0d", k), item(s, n), 2'(s));
      check($sformatf("t2.e%0d.stall", k), 64'(src_stall), 64'(es));
    end

    // Source 0 stalls after two accepts while source 2 stays backlogged.
    do_reset();
    base[0] = 32'h100; tbase[0] = 1; lim[0] = 4;
    base[2] = 32'h200; tbase[2] = 8; lim[2] = 100;
    tick();
    check_cdb("t3.e1", '0, 2'd0);
    check("t3.e1.stall", 64'(src_stall), 64'b000);
    begin
      int         exp_src [7] = '{0, 2, 0, 2, 0, 2, 0};
      int         exp_k   [7] = '{0, 0, 1, 1, 2, 2, 3};
      logic [2:0] exp_st  [7] = '{3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b000, 3'b100};
      for (int j = 0; j < 7; j++) begin
        tick();
        check_cdb($sformatf("t3.e%0d", j + 2), item(exp_src[j], exp_k[j]), 2'(exp_src[j]));
        check($sformatf("t3.e%0d.stall", j + 2), 64'(src_stall), 64'(exp_st[j]));
      end
    end
`endif

    // Squash with a new source-1 result: everything buffered and that result vanish.
    do_reset();
    for (int i = 0; i < NS; i++) lim[i] = 100;
    repeat (6) tick();
`ifndef CDB_ARB_FIXED_PRIO_EN
    check("t4.pre.stall", 64'(src_stall), 64'b101);
`endif
    squash = 1'b1;
    tick();
    squash = 1'b0;
    for (int i = 0; i < NS; i++) lim[i] = 0;
    check_cdb("t4.sq", '0, 2'd0);
    check("t4.sq.stall", 64'(src_stall), 64'b000);
    for (int j = 0; j < 3; j++) begin
      tick();
      check_cdb($sformatf("t4.post%0d", j), '0, 2'd0);
    end

    // Asynchronous reset mid-cycle while a broadcast is valid.
    do_reset();
    for (int i = 0; i < NS; i++) lim[i] = 100;
    tick();
    tick();
    check("t5.pre.valid", 64'(cdb_out.valid), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5.async.cdb", 64'(cdb_out), 64'h0);
    check("t5.async.stall", 64'(src_stall), 64'b000);
    check("t5.async.id", 64'(cdb_src_id), 64'h0);
    for (int i = 0; i < NS; i++) begin
      lim[i]      = 0;
      src_data[i] = '0;
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_cdb("t5.rel", '0, 2'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      check_cdb($sformatf("t5.post%0d", j), '0, 2'd0);
    end

    // Sources 0 and 2 backlogged: alternation (round-robin) or source 0 only (fixed).
    do_reset();
    lim[0] = 100;
    lim[2] = 100;
    tick();
    check_cdb("t6.e1", '0, 2'd0);
    for (int k = 2; k <= 7; k++) begin
      logic [1:0] eid;
      logic [2:0] es;
`ifdef CDB_ARB_FIXED_PRIO_EN
      eid = 2'd0;
      es  = 3'b100;
`else
      eid = (k % 2 == 0) ? 2'd0 : 2'd2;
      es  = (k % 2 == 0) ? 3'b100 : 3'b001;
`endif
      tick();
      check($sformatf("t6.e%0d.valid", k), 64'(cdb_out.valid), 64'h1);
      check($sformatf("t6.e%0d.id", k), 64'(cdb_src_id), 64'(eid));
      check($sformatf("t6.e%0d.stall", k), 64'(src_stall), 64'(es));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
